// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants and helpers for the BCD counter and its 7-segment scanner.
//   - SEG_GLYPH : active-high segment codes for decimal digits 0..9,
//                 bit order dp,g,f,e,d,c,b,a (dp always 0).
//   - SEG_BLANK : all segments off.
//   - DIGIT_OFF : all (active-low) digit enables off.
//   - seg_encode: nibble -> segment code; non-BCD nibbles go dark.
//   - bin_to_bcd: elaboration-time binary to packed BCD (up to 8 digits).
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_GLYPH [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] DIGIT_OFF = 8'hFF;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_BLANK;
    return SEG_GLYPH[digit];
  endfunction

  // Only used to build constants, so the divider never reaches hardware.
  function automatic logic [31:0] bin_to_bcd(input int value);
    logic [31:0] result;
    int          rem;
    result = '0;
    rem    = (value < 0) ? 0 : value;
    for (int i = 0; i < 8; i++) begin
      result[4*i +: 4] = 4'(rem % 10);
      rem              = rem / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
//   Time-multiplexes DIGITS packed BCD digits onto one 7-segment bus.
//   The scan index steps 0..DIGITS-1, one slot every SCAN_DIV clocks. The
//   segment pattern and its digit enable are registered from the same index,
//   so both pins change on the same edge, one clock after the index moves.
//
//   Ports:
//     clk       : system clock
//     rst       : asynchronous active-high reset
//     bcd       : packed BCD digits, digit 0 in bits [3:0]
//     seg_led   : segment pattern, active-high, dp,g,f,e,d,c,b,a
//     digtal_sw : digit enables, active-low; bits >= DIGITS stay high
// -----------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1,
  parameter int LZ_BLANK = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            seg_led,
  output logic [7:0]            digtal_sw
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0]     div_cnt;
  logic [IW-1:0]     idx;
  logic [DIGITS-1:0] zero_up;   // digit k and every digit above it are zero
  logic [3:0]        cur_digit;
  logic              blank;

  always_comb begin
    zero_up            = '0;
    zero_up[DIGITS-1]  = (bcd[4*DIGITS-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      zero_up[k] = (bcd[4*k +: 4] == 4'd0) && zero_up[k+1];
    end
    cur_digit = bcd[4*idx +: 4];
    // Digit 0 is never blanked, so a zero count still shows "0".
    blank     = (LZ_BLANK != 0) && (idx != '0) && zero_up[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      seg_led   <= SEG_BLANK;
      digtal_sw <= DIGIT_OFF;
    end else begin
      digtal_sw <= DIGIT_OFF & ~(8'd1 << idx);
      seg_led   <= blank ? SEG_BLANK : seg_encode(cur_digit);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// -----------------------------------------------------------------------------
// bcd_counter_display
//   Modulo-MODULUS up/down counter stepping once every TICK_DIV clocks, with
//   run/pause toggle, synchronous clear and clamped parallel load. A BCD copy
//   of the count is kept in lockstep (per-digit carry/borrow, no divider) and
//   scanned onto DIGITS multiplexed 7-segment digits by seg7_scan.
//
//   Ports:
//     clk        : system clock
//     rst        : asynchronous active-high reset
//     run_toggle : one-cycle pulse, flips run/pause
//     dir        : 0 = count up, 1 = count down (sampled on tick)
//     clear      : synchronous clear to 0 (highest priority)
//     load       : synchronous load of load_value (clamped to MODULUS-1)
//     load_value : value to load
//     count_out  : binary count
//     bcd_out    : BCD count, digit 0 in bits [3:0]
//     wrap       : one-cycle pulse on wrap-around
//     running    : run state
//     seg_led    : segment pattern, active-high, dp,g,f,e,d,c,b,a
//     digtal_sw  : digit enables, active-low
// -----------------------------------------------------------------------------
module bcd_counter_display
  import seg7_pkg::*;
#(
  parameter  int DIGITS   = 2,
  parameter  int MODULUS  = 20,
  parameter  int TICK_DIV = 100,
  parameter  int SCAN_DIV = 1,
  parameter  int LZ_BLANK = 0,
  localparam int CW       = $clog2(MODULUS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_toggle,
  input  logic                dir,
  input  logic                clear,
  input  logic                load,
  input  logic [CW-1:0]       load_value,
  output logic [CW-1:0]       count_out,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                wrap,
  output logic                running,
  output logic [7:0]          seg_led,
  output logic [7:0]          digtal_sw
);

  localparam int BW = 4 * DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] MAX_CNT   = CW'(MODULUS - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] MAX_BCD   = BW'(bin_to_bcd(MODULUS - 1));

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] load_clamped;
  logic [BW-1:0] load_bcd;
  logic [BW-1:0] bcd_inc;
  logic [BW-1:0] bcd_dec;

  // Tick uses the current running value, so a run_toggle in the same cycle
  // does not suppress or create a step.
  assign tick         = running && (tick_cnt == TICK_LAST);
  assign load_clamped = (load_value > MAX_CNT) ? MAX_CNT : load_value;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    logic carry;
    logic borrow;
    bcd_inc = bcd_out;
    bcd_dec = bcd_out;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd_out[4*d +: 4] == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          bcd_inc[4*d +: 4] = bcd_out[4*d +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd_out[4*d +: 4] == 4'd0) begin
          bcd_dec[4*d +: 4] = 4'd9;
        end else begin
          bcd_dec[4*d +: 4] = bcd_out[4*d +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Shift-and-add-3 conversion of the load value, unrolled into one cycle.
  always_comb begin
    load_bcd = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (load_bcd[4*d +: 4] >= 4'd5) load_bcd[4*d +: 4] = load_bcd[4*d +: 4] + 4'd3;
      end
      load_bcd = {load_bcd[BW-2:0], load_clamped[i]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      count_out <= '0;
      bcd_out   <= '0;
      wrap      <= 1'b0;
      running   <= 1'b1;
    end else begin
      wrap <= 1'b0;
      if (run_toggle) running <= ~running;

      if (clear) begin
        tick_cnt  <= '0;
        count_out <= '0;
        bcd_out   <= '0;
      end else if (load) begin
        tick_cnt  <= '0;
        count_out <= load_clamped;
        bcd_out   <= load_bcd;
      end else begin
        // Paused: hold the phase so resuming loses no partial period.
        if (running) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          if (!dir) begin
            if (count_out == MAX_CNT) begin
              count_out <= '0;
              bcd_out   <= '0;
              wrap      <= 1'b1;
            end else begin
              count_out <= count_out + 1'b1;
              bcd_out   <= bcd_inc;
            end
          end else begin
            if (count_out == '0) begin
              count_out <= MAX_CNT;
              bcd_out   <= MAX_BCD;
              wrap      <= 1'b1;
            end else begin
              count_out <= count_out - 1'b1;
              bcd_out   <= bcd_dec;
            end
          end
        end
      end
    end
  end

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .LZ_BLANK (LZ_BLANK)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd_out),
    .seg_led   (seg_led),
    .digtal_sw (digtal_sw)
  );

endmodule

// File: tb/tb_bcd_counter_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_display
//   dut_a: DIGITS=2, MODULUS=20, TICK_DIV=4, SCAN_DIV=1, no blanking
//          (counter behaviour and unblanked mux).
//   dut_b: DIGITS=3, MODULUS=20, TICK_DIV=1000, SCAN_DIV=2, blanking
//          (scan timing and leading-zero blanking).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_counter_display;

  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_run_toggle = 1'b0, a_dir = 1'b0, a_clear = 1'b0, a_load = 1'b0;
  logic [CW-1:0] a_load_value = '0;
  logic [CW-1:0] a_count;
  logic [7:0]    a_bcd;
  logic          a_wrap, a_running;
  logic [7:0]    a_seg, a_dsw;

  logic          b_run_toggle = 1'b0, b_dir = 1'b0, b_clear = 1'b0, b_load = 1'b0;
  logic [CW-1:0] b_load_value = '0;
  logic [CW-1:0] b_count;
  logic [11:0]   b_bcd;
  logic          b_wrap, b_running;
  logic [7:0]    b_seg, b_dsw;

  int passed = 0;
  int total  = 0;

  bcd_counter_display #(
    .DIGITS(2), .MODULUS(20), .TICK_DIV(4), .SCAN_DIV(1), .LZ_BLANK(0)
  ) dut_a (
    .clk(clk), .rst(rst), .run_toggle(a_run_toggle), .dir(a_dir),
    .clear(a_clear), .load(a_load), .load_value(a_load_value),
    .count_out(a_count), .bcd_out(a_bcd), .wrap(a_wrap), .running(a_running),
    .seg_led(a_seg), .digtal_sw(a_dsw)
  );

  bcd_counter_display #(
    .DIGITS(3), .MODULUS(20), .TICK_DIV(1000), .SCAN_DIV(2), .LZ_BLANK(1)
  ) dut_b (
    .clk(clk), .rst(rst), .run_toggle(b_run_toggle), .dir(b_dir),
    .clear(b_clear), .load(b_load), .load_value(b_load_value),
    .count_out(b_count), .bcd_out(b_bcd), .wrap(b_wrap), .running(b_running),
    .seg_led(b_seg), .digtal_sw(b_dsw)
  );

  // Observed dut_a state packed as {count, bcd, wrap, running}.
  wire [14:0] a_obs = {a_count, a_bcd, a_wrap, a_running};

  function automatic logic [14:0] st(input logic [4:0] c, input logic [7:0] b,
                                     input logic w, input logic r);
    return {c, b, w, r};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_load_pulse(input logic [CW-1:0] v);
    a_load = 1'b1; a_load_value = v;
    cyc(1);
    a_load = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] exp;
    cyc(2);
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL reset_state: {count,bcd,wrap,run} got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    total++;
    if ({a_dsw, a_seg, b_dsw, b_seg} !== 32'hFF00_FF00)
      $display("FAIL reset_pins: got dsw_a=%h seg_a=%h dsw_b=%h seg_b=%h exp FF 00 FF 00", a_dsw, a_seg, b_dsw, b_seg);
    else passed++;
    rst = 1'b0;
    // Edges 1..3 hold 0, edge 4 is the first step.
    for (int e = 1; e <= 4; e++) begin
      cyc(1);
      exp = (e < 4) ? st(5'd0, 8'h00, 1'b0, 1'b1) : st(5'd1, 8'h01, 1'b0, 1'b1);
      total++;
      if (a_obs !== exp)
        $display("FAIL first_tick_edge%0d: {count,bcd,wrap,run} got %h exp %h", e, a_obs, exp);
      else passed++;
    end
  endtask

  task automatic test_up_wrap;
    logic [15:0] s1, s2;
    a_dir = 1'b0;
    a_load_pulse(5'd19);
    total++;
    if (a_obs !== st(5'd19, 8'h19, 1'b0, 1'b1))
      $display("FAIL upwrap_load: got %h exp %h", a_obs, st(5'd19, 8'h19, 1'b0, 1'b1));
    else passed++;
    // Unblanked two-digit mux of 19: digit 0 shows 9, digit 1 shows 1.
    cyc(1); s1 = {a_dsw, a_seg};
    cyc(1); s2 = {a_dsw, a_seg};
    total++;
    if (!((s1 == 16'hFE6F || s1 == 16'hFD06) && (s2 == 16'hFE6F || s2 == 16'hFD06) && s1 != s2))
      $display("FAIL mux_a: {dsw,seg} got %h then %h exp alternating FE6F/FD06", s1, s2);
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd19, 8'h19, 1'b0, 1'b1))
      $display("FAIL upwrap_hold: got %h exp %h", a_obs, st(5'd19, 8'h19, 1'b0, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b1, 1'b1))
      $display("FAIL upwrap_step: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b1, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL upwrap_pulse_end: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
  endtask

  task automatic test_down_wrap;
    a_dir = 1'b1;
    a_clear = 1'b1; cyc(1); a_clear = 1'b0;
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL down_clear: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(4);
    total++;
    if (a_obs !== st(5'd19, 8'h19, 1'b1, 1'b1))
      $display("FAIL downwrap_step: got %h exp %h", a_obs, st(5'd19, 8'h19, 1'b1, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd19, 8'h19, 1'b0, 1'b1))
      $display("FAIL downwrap_pulse_end: got %h exp %h", a_obs, st(5'd19, 8'h19, 1'b0, 1'b1));
    else passed++;
    cyc(3);
    total++;
    if (a_obs !== st(5'd18, 8'h18, 1'b0, 1'b1))
      $display("FAIL down_next: got %h exp %h", a_obs, st(5'd18, 8'h18, 1'b0, 1'b1));
    else passed++;
  endtask

  task automatic test_bcd_carry;
    a_dir = 1'b0;
    a_load_pulse(5'd9);
    cyc(4);
    total++;
    if (a_obs !== st(5'd10, 8'h10, 1'b0, 1'b1))
      $display("FAIL bcd_carry: got %h exp %h", a_obs, st(5'd10, 8'h10, 1'b0, 1'b1));
    else passed++;
    a_dir = 1'b1;
    cyc(4);
    total++;
    if (a_obs !== st(5'd9, 8'h09, 1'b0, 1'b1))
      $display("FAIL bcd_borrow: got %h exp %h", a_obs, st(5'd9, 8'h09, 1'b0, 1'b1));
    else passed++;
  endtask

  task automatic test_pause;
    int bad;
    a_dir = 1'b0;
    a_clear = 1'b1; cyc(1); a_clear = 1'b0;   // tick counter 0
    cyc(1);                                    // tick counter 1
    a_run_toggle = 1'b1; cyc(1); a_run_toggle = 1'b0;  // counter 2, paused
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b0))
      $display("FAIL pause_enter: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b0));
    else passed++;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b0)) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL pause_hold: %0d bad cycles of 50, exp 0", bad);
    else passed++;
    a_run_toggle = 1'b1; cyc(1); a_run_toggle = 1'b0;
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL resume_edge: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL resume_plus1: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd1, 8'h01, 1'b0, 1'b1))
      $display("FAIL resume_plus2: got %h exp %h", a_obs, st(5'd1, 8'h01, 1'b0, 1'b1));
    else passed++;
  endtask

  task automatic test_priority;
    a_dir = 1'b0;
    a_load_pulse(5'd19);
    cyc(3);   // next edge would tick and wrap
    a_clear = 1'b1; a_load = 1'b1; a_load_value = 5'd7;
    cyc(1);
    a_clear = 1'b0; a_load = 1'b0;
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL prio_clear: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(3);
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL prio_phase_reset: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd1, 8'h01, 1'b0, 1'b1))
      $display("FAIL prio_after: got %h exp %h", a_obs, st(5'd1, 8'h01, 1'b0, 1'b1));
    else passed++;
    a_load_pulse(5'd25);
    total++;
    if (a_obs !== st(5'd19, 8'h19, 1'b0, 1'b1))
      $display("FAIL load_clamp: got %h exp %h", a_obs, st(5'd19, 8'h19, 1'b0, 1'b1));
    else passed++;
    cyc(3);
    a_load_pulse(5'd7);   // coincides with a wrapping tick
    total++;
    if (a_obs !== st(5'd7, 8'h07, 1'b0, 1'b1))
      $display("FAIL load_beats_tick: got %h exp %h", a_obs, st(5'd7, 8'h07, 1'b0, 1'b1));
    else passed++;
  endtask

  task automatic test_scan;
    logic [7:0]  prev;
    logic [15:0] exp;
    bit          found;
    b_run_toggle = 1'b1; b_load = 1'b1; b_load_value = 5'd5;
    cyc(1);
    b_run_toggle = 1'b0; b_load = 1'b0;
    total++;
    if ({b_count, b_bcd, b_wrap, b_running} !== {5'd5, 12'h005, 1'b0, 1'b0})
      $display("FAIL scan_setup: count=%0d bcd=%h wrap=%b run=%b exp 5 005 0 0", b_count, b_bcd, b_wrap, b_running);
    else passed++;
    found = 1'b0;
    prev  = b_dsw;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (b_dsw == 8'hFE && prev != 8'hFE) found = 1'b1;
      else prev = b_dsw;
    end
    total++;
    if (!found) $display("FAIL scan_sync: digtal_sw never entered FE, last %h", b_dsw);
    else passed++;
    if (found) begin
      for (int i = 0; i < 12; i++) begin
        case ((i / 2) % 3)
          0:       exp = 16'hFE6D;
          1:       exp = 16'hFD00;
          default: exp = 16'hFB00;
        endcase
        total++;
        if ({b_dsw, b_seg} !== exp)
          $display("FAIL scan_slot%0d: {dsw,seg} got %h exp %h", i, {b_dsw, b_seg}, exp);
        else passed++;
        cyc(1);
      end
    end
  endtask

  task automatic test_reset_mid;
    a_dir = 1'b0;
    a_load_pulse(5'd13);
    #2 rst = 1'b1;
    #1;
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1) || a_dsw !== 8'hFF || a_seg !== 8'h00)
      $display("FAIL reset_async: state %h dsw %h seg %h exp %h FF 00", a_obs, a_dsw, a_seg, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    total++;
    if (a_obs !== st(5'd0, 8'h00, 1'b0, 1'b1))
      $display("FAIL reset_release_quiet: got %h exp %h", a_obs, st(5'd0, 8'h00, 1'b0, 1'b1));
    else passed++;
    cyc(1);
    total++;
    if (a_obs !== st(5'd1, 8'h01, 1'b0, 1'b1))
      $display("FAIL reset_release_step: got %h exp %h", a_obs, st(5'd1, 8'h01, 1'b0, 1'b1));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_bcd_carry();
    test_pause();
    test_priority();
    test_scan();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parametrised successor to the two-digit mod-20 seconds counter.
- Runs a modulo-MODULUS up/down counter that advances once every TICK_DIV clocks. It supports run/pause toggle, synchronous clear and parallel load.
- Drives DIGITS multiplexed 7-segment digits in BCD, with optional leading-zero blanking.
- Sits between the debounce block (it consumes one-cycle pulses from it) and the board's segment and digit pins.

Parameters:
- DIGITS, 2: number of displayed decimal digits; legal range 1..8.
- MODULUS, 20: count range 0..MODULUS-1; must be <= 10**DIGITS.
- TICK_DIV, 100: clocks per count step. Exact period; legal values >= 2.
- SCAN_DIV, 1: clocks per digit-scan slot; legal values >= 1.
- LZ_BLANK, 0: 1 blanks leading zero digits. The least significant digit is never blanked.
- CW, $clog2(MODULUS): binary count width (localparam).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- run_toggle, input, 1: one-cycle pulse that flips the run/pause state.
- dir, input, 1: 0 counts up, 1 counts down. Sampled on each tick.
- clear, input, 1: synchronous clear to 0.
- load, input, 1: synchronous load of load_value.
- load_value, input, CW: value for load. Values >= MODULUS are clamped to MODULUS-1.
- count_out, output, CW: current binary count.
- bcd_out, output, 4*DIGITS: current BCD digits; digit 0 in bits [3:0].
- wrap, output, 1: one-cycle pulse on wrap-around (MODULUS-1 to 0 going up, 0 to MODULUS-1 going down).
- running, output, 1: current run state.
- seg_led, output, 8: segment pattern, active-high, bit order dp,g,f,e,d,c,b,a; dp is always 0.
- digtal_sw, output, 8: digit enables, active-low. Bit k drives digit k; bits >= DIGITS are held at 1.

Behaviour:
- Reset values (asynchronous, all registered):
  - count_out=0, bcd_out=0, wrap=0, running=1.
  - Tick counter=0, scan index=0.
  - digtal_sw=8'hFF, seg_led=8'h00.
- Tick generation:
  - The tick counter counts 0..TICK_DIV-1 only while running=1, and wraps to 0.
  - A tick is asserted in the cycle the counter equals TICK_DIV-1, so the first step after reset occurs at clock edge TICK_DIV.
  - While paused, the tick counter holds its value. Resuming continues from the held value, so no partial period is lost.
- run_toggle flips running on the next edge. A tick in the same cycle as run_toggle uses the old running value.
- Priority per cycle is clear > load > tick.
  - clear or load also zeroes the tick counter.
  - clear or load never asserts wrap.
- Count step on tick:
  - Up: count+1, or 0 when count=MODULUS-1, with wrap=1.
  - Down: count-1, or MODULUS-1 when count=0, with wrap=1.
  - wrap is registered and high for exactly one cycle.
- BCD:
  - bcd_out is maintained incrementally in lockstep with count_out, with per-digit carry/borrow. No divider is used.
  - On load or wrap-to-max, bcd_out is set from a per-cycle iterative conversion, or from a constant for MODULUS-1.
  - Invariant every cycle: bcd_out decodes to count_out.
- Scan:
  - The scan index advances 0..DIGITS-1 every SCAN_DIV clocks.
  - digtal_sw and seg_led are registered together from the same index, so the pattern and its enable change on the same edge. Latency from index change to pins is 1 clock.
  - With DIGITS=1, digit 0 is permanently enabled.
- Blanking: when LZ_BLANK=1, digit k>0 shows seg_led=0 if it and all higher digits are 0. Its enable bit still asserts.
- Glyphs: digits 0..9 use the standard codes 3F,06,5B,4F,66,6D,7D,07,7F,6F. Non-BCD nibbles display 00.
- Reset mid-operation forces all reset values immediately. No tick or wrap is emitted on reset release.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_GLYPH[0:9] constants, SEG_BLANK=8'h00, DIGIT_OFF=8'hFF.
  - A function bin_to_bcd for elaboration-time constants.
- Sub-module seg7_scan (parameters DIGITS, SCAN_DIV, LZ_BLANK): takes bcd_out and produces the registered seg_led and digtal_sw. The counter core stays in bcd_counter_display.

Test Plan:
- Reset/first tick (TICK_DIV=4): release rst, then count_out=0 for edges 1-3, count_out=1 and bcd_out=8'h01 at edge 4, and running=1 throughout.
- Up-wrap (MODULUS=20): load 19, then tick. Required: count_out=0, bcd_out=8'h00, wrap high for exactly 1 cycle.
- Down-wrap, dir=1 from 0: one tick gives count_out=19, bcd_out=8'h19, wrap pulse. The next tick gives 18 with no wrap.
- Pause/resume: run_toggle when the tick counter is 2 (TICK_DIV=4), hold for 50 clocks, then toggle again. Required: count unchanged during the pause, and the next step 2 clocks after resume.
- Priority: clear, load=7 and a tick in the same cycle give count_out=0 with no wrap. load=25 alone gives count_out=19.
- Scan (DIGITS=3, SCAN_DIV=2, LZ_BLANK=1, count=5): digtal_sw cycles FE, FD, FB, holding each for 2 clocks. seg_led shows 6D with digit 0 enabled and 00 with digit 1 or 2 enabled.
